class_argmax_stream: RTL and testbench
======================================

CLASS_ARGMAX_STREAM -- requirements
Module: class_argmax_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 16, score width in bits.
REQ-002 SHALL have parameter NUM_CLASS, default 10, scores per frame (range 2..256).
REQ-003 SHALL have parameter IDX_W, default 4, index width; IDX_W >= clog2(NUM_CLASS).
REQ-004 SHALL have parameter SIGNED_CMP, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port clr, input, 1 bit: synchronous frame abort.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a score.
REQ-010 SHALL have port in_data, input, DATA_W bits: one class score per beat, class 0 first.
REQ-011 SHALL have port in_last, input, 1 bit: final score of the frame.
REQ-012 SHALL have port out_valid, output, 1 bit: result held.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-014 SHALL have port out_value, output, DATA_W bits: maximum score.
REQ-015 SHALL have port out_index, output, IDX_W bits: class index of the maximum.
REQ-016 SHALL have port out_err, output, 1 bit: frame length mismatch.

Function
REQ-017 SHALL define a beat as accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-018 SHALL implement a two-state FSM, ACC and HOLD; in_ready = 1 in ACC and 0 in HOLD; out_valid = 1 exactly in HOLD.
REQ-019 SHALL, in ACC, load the running max and its index from the first accepted beat of a frame.
REQ-020 SHALL, in ACC, replace the running max on each later beat only if in_data is strictly greater (per SIGNED_CMP); ties keep the lowest index.
REQ-021 SHALL keep a beat counter that starts at 0 per frame and increments per accepted beat.
REQ-022 SHALL end the frame on an accepted beat with in_last = 1, or on the NUM_CLASS-th accepted beat, whichever comes first.
REQ-023 SHALL, at frame end, register the result, including that final beat, and enter HOLD; out_valid rises on the cycle after the final accepted beat.
REQ-024 SHALL set out_err = 1 when in_last is seen at count != NUM_CLASS-1, or when the NUM_CLASS-th beat lacks in_last; otherwise out_err = 0.
REQ-025 SHALL hold out_value, out_index and out_err stable in HOLD until out_valid && out_ready, then return to ACC with the counter cleared.
REQ-026 SHALL sustain throughput of 1 frame per NUM_CLASS+1 cycles when out_ready is held at 1.
REQ-027 SHALL, when clr = 1, enter ACC, clear the counter and deassert out_valid next cycle; clr has priority over every other event, including a same-cycle handshake.

Reset
REQ-028 SHALL, while rst_n = 0, force FSM = ACC, counter = 0, out_valid = 0, out_value = 0, out_index = 0, out_err = 0 (and the margin outputs to 0 when enabled), regardless of any frame in progress.
REQ-029 SHALL discard any partial frame on reset; the first beat accepted after rst_n deasserts is class 0.

Configuration
REQ-030 SHALL, when ARGMAX_MARGIN_EN is defined, add output out_second (DATA_W bits, runner-up score; ties go to the lower index) and output out_margin (DATA_W+1 bits, out_value - out_second, sign-extended per SIGNED_CMP, never negative), both valid and held with out_valid.
REQ-031 SHALL, when ARGMAX_MARGIN_EN is undefined, omit out_second, out_margin and the runner-up tracking logic; all other behaviour is unchanged.

Verification
REQ-032 SHALL cover: defaults, SIGNED_CMP = 1, scores 5,-3,100,7,100,0,-128,2,9,99 with in_last on beat 10 -> out_value = 100, out_index = 2, out_err = 0, out_valid one cycle after beat 10.
REQ-033 SHALL cover: SIGNED_CMP = 0 with scores 0x7FFF, 0x8000 and 0 elsewhere -> out_index = 1, out_value = 0x8000; with SIGNED_CMP = 1 the same frame gives out_index = 0.
REQ-034 SHALL cover: in_last on beat 6 -> result over beats 0..5 with out_err = 1; a frame of 10 beats with no in_last -> out_err = 1.
REQ-035 SHALL cover: out_ready held 0 for 20 cycles -> in_ready = 0 and outputs stable; out_ready pulsed -> next frame accepted from class 0.
REQ-036 SHALL cover: clr or rst_n asserted at beat 4 -> no out_valid; the following full frame produces the correct result.
REQ-037 SHALL cover: ARGMAX_MARGIN_EN defined with scores 40, 90, 90, 10 (others 0) -> out_index = 1, out_second = 90, out_margin = 0.

Source files
------------

// File: rtl/class_argmax_stream.sv
// Streaming argmax over NUM_CLASS scores per frame, with a one-result hold stage.
// Define ARGMAX_MARGIN_EN to add runner-up (out_second) and margin (out_margin) outputs.
module class_argmax_stream #(
   parameter int DATA_W     = 16,
   parameter int NUM_CLASS  = 10,
   parameter int IDX_W      = 4,
   parameter int SIGNED_CMP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_value,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_err
`ifdef ARGMAX_MARGIN_EN
   ,
   output logic [DATA_W-1:0] out_second,
   output logic [DATA_W:0]   out_margin
`endif
);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    cnt_reg;
   logic [DATA_W-1:0]   max_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic                err_reg;

   logic                accept;
   logic                first_beat;
   logic                last_count;
   logic                frame_end;

   function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (SIGNED_CMP != 0)
         return $signed(a) > $signed(b);
      else
         return a > b;
   endfunction

   assign accept     = in_valid & in_ready;
   assign first_beat = (cnt_reg == '0);
   assign last_count = (cnt_reg == IDX_W'(NUM_CLASS - 1));
   assign frame_end  = accept & (in_last | last_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ACC;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (clr) begin
         state_next = ACC;
      end else begin
         case (state_reg)
            ACC:     if (frame_end) state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACC;
            default: state_next = ACC;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_reg == ACC);
      out_valid = (state_reg == HOLD);
   end

   // Running max doubles as the result register: it is frozen while in HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         max_reg <= '0;
         idx_reg <= '0;
         err_reg <= 1'b0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= frame_end ? '0 : cnt_reg + IDX_W'(1);
         if (first_beat || greater(in_data, max_reg)) begin
            max_reg <= in_data;
            idx_reg <= cnt_reg;
         end
         if (frame_end)
            err_reg <= in_last ^ last_count;
      end
   end

   assign out_value = max_reg;
   assign out_index = idx_reg;
   assign out_err   = err_reg;

`ifdef ARGMAX_MARGIN_EN
   logic [DATA_W-1:0] second_reg;
   logic              sec_valid_reg;
   logic [DATA_W:0]   max_ext;
   logic [DATA_W:0]   sec_ext;

   // A one-beat frame reports its only score as runner-up too, giving margin 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         second_reg    <= '0;
         sec_valid_reg <= 1'b0;
      end else if (!clr && accept) begin
         if (first_beat) begin
            second_reg    <= in_data;
            sec_valid_reg <= 1'b0;
         end else if (greater(in_data, max_reg)) begin
            second_reg    <= max_reg;
            sec_valid_reg <= 1'b1;
         end else if (!sec_valid_reg || greater(in_data, second_reg)) begin
            second_reg    <= in_data;
            sec_valid_reg <= 1'b1;
         end
      end
   end

   generate
      if (SIGNED_CMP != 0) begin : g_sext
         assign max_ext = {max_reg[DATA_W-1], max_reg};
         assign sec_ext = {second_reg[DATA_W-1], second_reg};
      end else begin : g_zext
         assign max_ext = {1'b0, max_reg};
         assign sec_ext = {1'b0, second_reg};
      end
   endgenerate

   assign out_second = second_reg;
   assign out_margin = max_ext - sec_ext;
`endif

endmodule

// File: tb/tb_class_argmax_stream.sv
// Directed bench: signed and unsigned instances share one stimulus stream.
module tb_class_argmax_stream;
   localparam int DW = 16;
   localparam int NC = 10;
   localparam int IW = 4;

   typedef struct packed {
      logic [9:0][15:0] sc;
      logic [4:0]       nbeats;
      logic [4:0]       last_at;   // 31 = no in_last in frame
      logic             e;
      logic [15:0]      vs;
      logic [3:0]       is_;
      logic [15:0]      ss;
      logic [16:0]      ms;
      logic [15:0]      vu;
      logic [3:0]       iu;
      logic [15:0]      su;
      logic [16:0]      mu;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic in_ready_s, out_valid_s, out_err_s, in_ready_u, out_valid_u, out_err_u;
   logic [DW-1:0] out_value_s, out_value_u;
   logic [IW-1:0] out_index_s, out_index_u;
`ifdef ARGMAX_MARGIN_EN
   logic [DW-1:0] out_second_s, out_second_u;
   logic [DW:0]   out_margin_s, out_margin_u;
`endif

   int checks = 0;
   int errors = 0;
   vec_t vecs [6];

   always #5 clk = ~clk;

   class_argmax_stream #(.DATA_W(DW), .NUM_CLASS(NC), .IDX_W(IW), .SIGNED_CMP(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_value(out_value_s), .out_index(out_index_s), .out_err(out_err_s)
`ifdef ARGMAX_MARGIN_EN
      , .out_second(out_second_s), .out_margin(out_margin_s)
`endif
   );

   class_argmax_stream #(.DATA_W(DW), .NUM_CLASS(NC), .IDX_W(IW), .SIGNED_CMP(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
      .out_value(out_value_u), .out_index(out_index_u), .out_err(out_err_u)
`ifdef ARGMAX_MARGIN_EN
      , .out_second(out_second_u), .out_margin(out_margin_u)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat was taken.
   task automatic drive_beat(input logic [15:0] d, input logic last, input logic c);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_last = last; clr = c;
      while (!in_ready_s && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready_s) begin
         checks++; errors++;
         $display("FAIL beat_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
   endtask

   task automatic send_frame(input vec_t v);
      for (int b = 0; b < int'(v.nbeats); b++)
         drive_beat(v.sc[b], (b == int'(v.last_at)), 1'b0);
   endtask

   task automatic check_vec(input int i, input vec_t v);
      $display("frame %0d: s value=%0h index=%0d err=%0d | u value=%0h index=%0d err=%0d",
               i, out_value_s, out_index_s, out_err_s, out_value_u, out_index_u, out_err_u);
      chk("out_valid_s", out_valid_s, 1);
      chk("out_valid_u", out_valid_u, 1);
      chk("value_s", out_value_s, v.vs);
      chk("index_s", out_index_s, v.is_);
      chk("err_s",   out_err_s,   v.e);
      chk("value_u", out_value_u, v.vu);
      chk("index_u", out_index_u, v.iu);
      chk("err_u",   out_err_u,   v.e);
`ifdef ARGMAX_MARGIN_EN
      chk("second_s", out_second_s, v.ss);
      chk("margin_s", out_margin_s, v.ms);
      chk("second_u", out_second_u, v.su);
      chk("margin_u", out_margin_u, v.mu);
`endif
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid_s, 0);
      chk("in_ready_back", in_ready_s, 1);
   endtask

   initial begin
      vecs[0] = '{sc: {16'd99, 16'd9, 16'd2, 16'hFF80, 16'd0, 16'd100, 16'd7, 16'd100, 16'hFFFD, 16'd5},
                  nbeats: 5'd10, last_at: 5'd9, e: 1'b0,
                  vs: 16'd100, is_: 4'd2, ss: 16'd100, ms: 17'd0,
                  vu: 16'hFFFD, iu: 4'd1, su: 16'hFF80, mu: 17'd125};
      vecs[1] = '{sc: {{8{16'h0000}}, 16'h8000, 16'h7FFF},
                  nbeats: 5'd10, last_at: 5'd9, e: 1'b0,
                  vs: 16'h7FFF, is_: 4'd0, ss: 16'h0000, ms: 17'h07FFF,
                  vu: 16'h8000, iu: 4'd1, su: 16'h7FFF, mu: 17'd1};
      vecs[2] = '{sc: {{4{16'h0000}}, 16'd5, 16'd4, 16'd9, 16'd3, 16'd2, 16'd1},
                  nbeats: 5'd6, last_at: 5'd5, e: 1'b1,
                  vs: 16'd9, is_: 4'd3, ss: 16'd5, ms: 17'd4,
                  vu: 16'd9, iu: 4'd3, su: 16'd5, mu: 17'd4};
      vecs[3] = '{sc: {16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd7, 16'd3, 16'd7, 16'd3, 16'd3},
                  nbeats: 5'd10, last_at: 5'd31, e: 1'b1,
                  vs: 16'd7, is_: 4'd2, ss: 16'd7, ms: 17'd0,
                  vu: 16'd7, iu: 4'd2, su: 16'd7, mu: 17'd0};
      vecs[4] = '{sc: {16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFD, 16'hFFF9, 16'hFFFE, 16'hFFF7, 16'hFFFE, 16'hFFFB},
                  nbeats: 5'd10, last_at: 5'd9, e: 1'b0,
                  vs: 16'hFFFE, is_: 4'd1, ss: 16'hFFFE, ms: 17'd0,
                  vu: 16'hFFFE, iu: 4'd1, su: 16'hFFFE, mu: 17'd0};
      vecs[5] = '{sc: {{6{16'h0000}}, 16'd10, 16'd90, 16'd90, 16'd40},
                  nbeats: 5'd10, last_at: 5'd9, e: 1'b0,
                  vs: 16'd90, is_: 4'd1, ss: 16'd90, ms: 17'd0,
                  vu: 16'd90, iu: 4'd1, su: 16'd90, mu: 17'd0};

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_out_valid", out_valid_s, 0);
      chk("rst_in_ready", in_ready_s, 1);
      chk("rst_value", out_value_s, 0);
      chk("rst_index", out_index_s, 0);
      chk("rst_err", out_err_s, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i]);
         check_vec(i, vecs[i]);
         release_out();
      end

      // Consumer stalls for 20 cycles while a producer keeps offering data
      send_frame(vecs[1]);
      in_valid = 1'b1; in_data = 16'h7FFE; in_last = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("hold_in_ready", in_ready_s, 0);
         chk("hold_valid", out_valid_s, 1);
         chk("hold_value_u", out_value_u, 16'h8000);
         chk("hold_index_s", out_index_s, 0);
      end
      $display("hold: 20 stalled cycles, value_s=%0h index_u=%0d", out_value_s, out_index_u);
      in_valid = 1'b0; in_last = 1'b0;
      release_out();
      send_frame(vecs[0]);
      check_vec(10, vecs[0]);
      release_out();

      // Back-to-back frames with out_ready tied high: one HOLD cycle per frame
      out_ready = 1'b1;
      send_frame(vecs[0]);
      chk("tput_valid", out_valid_s, 1);
      chk("tput_index", out_index_s, 2);
      @(posedge clk); #1;
      chk("tput_drop", out_valid_s, 0);
      chk("tput_ready", in_ready_s, 1);
      send_frame(vecs[5]);
      chk("tput2_valid", out_valid_s, 1);
      chk("tput2_index", out_index_s, 1);
      $display("throughput: two frames, second index=%0d", out_index_s);
      @(posedge clk); #1;
      out_ready = 1'b0;

      // clr on beat 4 aborts the frame
      for (int b = 0; b < 4; b++) drive_beat(vecs[0].sc[b], 1'b0, 1'b0);
      drive_beat(vecs[0].sc[4], 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         chk("clr_no_valid", out_valid_s, 0);
         @(posedge clk); #1;
      end
      $display("clr at beat 4: out_valid=%0d", out_valid_s);
      send_frame(vecs[0]);
      check_vec(11, vecs[0]);
      release_out();

      // clr coinciding with the final beat wins over frame end
      for (int b = 0; b < 9; b++) drive_beat(vecs[0].sc[b], 1'b0, 1'b0);
      drive_beat(vecs[0].sc[9], 1'b1, 1'b1);
      chk("clr_last_no_valid", out_valid_s, 0);
      chk("clr_last_ready", in_ready_s, 1);
      send_frame(vecs[2]);
      check_vec(12, vecs[2]);
      release_out();

      // Asynchronous reset on beat 4
      for (int b = 0; b < 4; b++) drive_beat(vecs[0].sc[b], 1'b0, 1'b0);
      in_valid = 1'b1; in_data = vecs[0].sc[4];
      #2 rst_n = 1'b0;
      #1;
      chk("arst_value", out_value_s, 0);
      chk("arst_index", out_index_u, 0);
      chk("arst_valid", out_valid_s, 0);
      chk("arst_ready", in_ready_s, 1);
      $display("reset at beat 4: value=%0h valid=%0d", out_value_s, out_valid_s);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_still_idle", out_valid_s, 0);
      send_frame(vecs[0]);
      check_vec(13, vecs[0]);
      release_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
